// File: rtl/mem_arb_rr_pkg.sv
// mem_arb_rr_pkg: shared arbiter state type and display-client bus width defaults
package mem_arb_rr_pkg;
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACK} arb_state_t;
  localparam int AN_DEF = 24;
  localparam int DN_DEF = 16;
endpackage

// File: rtl/mem_arb_rr_id_fifo.sv
// id_fifo: in-order queue of client IDs for outstanding reads; push and pop may coincide even when full
module id_fifo #(
  parameter int W = 2,
  parameter int D = 4
) (
  input  logic         clkSYS,
  input  logic         n_reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic rd_en, wr_en;
  assign full = cnt == (PW+1)'(D);
  assign empty = cnt == '0;
  assign head = mem[rp];
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  always_ff @(posedge clkSYS or negedge n_reset)
    if (!n_reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
      cnt <= cnt + (PW+1)'(wr_en) - (PW+1)'(rd_en);
    end
  always_ff @(posedge clkSYS)
    if (wr_en) mem[wp] <= din;
endmodule

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: round-robin arbiter of N clients onto one memory port, routing in-order read returns by ID
module mem_arb_rr
  import mem_arb_rr_pkg::*;
#(
  parameter int N = 4,
  parameter int AN = AN_DEF,
  parameter int DN = DN_DEF,
  parameter int FD = 4
) (
  input  logic                  clkSYS,
  input  logic                  n_reset,
  input  logic [N-1:0]          req,
  output logic [N-1:0]          ack,
  input  logic [N-1:0][AN-1:0]  addr,
  input  logic [N-1:0][DN-1:0]  data,
  input  logic [N-1:0]          wr,
  output logic [N-1:0]          rvalid,
  output logic [DN-1:0]         rdata,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [AN-1:0]         mem_addr,
  output logic [DN-1:0]         mem_data,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [DN-1:0]         mem_rdata
);
  localparam int IW = $clog2(N);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  arb_state_t state;
  logic [IW-1:0] g, last, win, idx, head;
  logic [N-1:0] elig;
  logic win_ok, after_ack, full, empty, push, err;
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++)
      elig[i] = req[i] && !(after_ack && IW'(i) == g) && (wr[i] || !full);
  end
  // Scan from farthest to nearest so the client closest after last wins.
  always_comb begin
    win = '0;
    win_ok = 1'b0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % N);
      if (elig[idx]) begin
        win = idx;
        win_ok = 1'b1;
      end
    end
  end
  assign push = state == S_GRANT && mem_ack && !mem_wr;
  assign rvalid = (mem_rvalid && !empty) ? ONE << head : '0;
  assign rdata = mem_rdata;
  always_ff @(posedge clkSYS or negedge n_reset)
    if (!n_reset) begin
      state <= S_IDLE;
      g <= '0;
      last <= IW'(N - 1);
      after_ack <= 1'b0;
      mem_req <= 1'b0;
      mem_wr <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      ack <= '0;
    end else
      case (state)
        S_IDLE: begin
          after_ack <= 1'b0;
          if (win_ok) begin
            g <= win;
            mem_addr <= addr[win];
            mem_data <= data[win];
            mem_wr <= wr[win];
            mem_req <= 1'b1;
            state <= S_GRANT;
          end
        end
        S_GRANT:
          if (mem_ack) begin
            mem_req <= 1'b0;
            last <= g;
            ack <= ONE << g;
            state <= S_ACK;
          end
        S_ACK: begin
          ack <= '0;
          after_ack <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
  // Sticky flag for a read return that arrives with no outstanding ID.
  always_ff @(posedge clkSYS or negedge n_reset)
    if (!n_reset) err <= 1'b0;
    else if (mem_rvalid && empty) err <= 1'b1;
  id_fifo #(.W(IW), .D(FD)) u_ids (
    .clkSYS(clkSYS),
    .n_reset(n_reset),
    .push(push),
    .pop(mem_rvalid),
    .din(g),
    .full(full),
    .empty(empty),
    .head(head)
  );
endmodule

// File: tb/tb_mem_arb_rr.sv
// tb_mem_arb_rr: directed scenarios plus randomized traffic checked against a round-robin/queue reference model
module tb_mem_arb_rr;
  logic clk, n_reset;
  logic [3:0] req, ack, wr, rvalid;
  logic [3:0][23:0] addr;
  logic [3:0][15:0] data;
  logic [15:0] rdata, mem_data, mem_rdata;
  logic [23:0] mem_addr;
  logic mem_req, mem_wr, mem_ack, mem_rvalid;
  int n_cmp = 0, n_bad = 0;

  mem_arb_rr dut (
    .clkSYS(clk), .n_reset(n_reset), .req(req), .ack(ack), .addr(addr), .data(data), .wr(wr),
    .rvalid(rvalid), .rdata(rdata), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int rr_pick(logic [3:0] r, logic [3:0] w, int lst, int excl, bit full);
    for (int k = 1; k <= 4; k++) begin
      int i = (lst + k) % 4;
      if (r[i] && i != excl && (w[i] || !full)) return i;
    end
    return -1;
  endfunction

  task automatic do_reset;
    n_reset = 0;
    req = 0; wr = 0; addr = '0; data = '0;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = 0;
    @(negedge clk);
    @(negedge clk);
    n_reset = 1;
  endtask

  task automatic test_reset;
    n_reset = 0;
    req = 0; wr = 0; addr = '0; data = '0;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = 0;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_wr, ack, rvalid} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got req=%b wr=%b ack=%b rvalid=%b, expected all 0", mem_req, mem_wr, ack, rvalid);
    end
    n_cmp++;
    if ({mem_addr, mem_data} !== 40'h0) begin
      n_bad++;
      $display("FAIL reset_bus: got addr=%h data=%h, expected 0", mem_addr, mem_data);
    end
    n_cmp++;
    if (dut.err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_err: got %b expected 0", dut.err);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g [3] = '{4'b0001, 4'b0100, 4'b0001};
    logic [3:0] seen [$];
    int at [$];
    do_reset();
    req = 4'b0101; wr = 4'b0101; mem_ack = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        seen.push_back(ack);
        at.push_back(c);
      end
    end
    n_cmp++;
    if (seen.size() < 3) begin
      n_bad++;
      $display("FAIL rr_count: got %0d acks expected at least 3", seen.size());
    end else
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (seen[k] !== exp_g[k]) begin
          n_bad++;
          $display("FAIL rr_order[%0d]: got %b expected %b", k, seen[k], exp_g[k]);
        end
        if (k > 0) begin
          n_cmp++;
          if (at[k] - at[k-1] != 3) begin
            n_bad++;
            $display("FAIL rr_spacing[%0d]: got %0d cycles expected 3", k, at[k] - at[k-1]);
          end
        end
      end
  endtask

  task automatic test_write_hold;
    int c;
    do_reset();
    req = 4'b0010; wr = 4'b0010; addr[1] = 24'h00012C; data[1] = 16'hF800; mem_ack = 0;
    for (c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    n_cmp++;
    if (!mem_req) begin
      n_bad++;
      $display("FAIL wr_grant_timeout: got mem_req=%b expected 1", mem_req);
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({mem_req, mem_wr, mem_addr, mem_data, ack} !== {1'b1, 1'b1, 24'h00012C, 16'hF800, 4'b0}) begin
        n_bad++;
        $display("FAIL wr_hold[%0d]: got req=%b wr=%b addr=%h data=%h ack=%b expected 1 1 00012c f800 0000",
                 k, mem_req, mem_wr, mem_addr, mem_data, ack);
      end
      if (k == 4) mem_ack = 1;
      @(negedge clk);
    end
    n_cmp++;
    if ({ack, mem_req} !== {4'b0010, 1'b0}) begin
      n_bad++;
      $display("FAIL wr_ack: got ack=%b mem_req=%b expected 0010 0", ack, mem_req);
    end
    mem_ack = 0; req = 0;
    @(negedge clk);
    n_cmp++;
    if (ack !== 4'b0) begin
      n_bad++;
      $display("FAIL wr_ack_pulse: got %b expected 0000", ack);
    end
  endtask

  task automatic test_drop_req;
    do_reset();
    req = 4'b0100; wr = 4'b0100; mem_ack = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    req = 0;
    @(negedge clk);
    mem_ack = 1;
    @(negedge clk);
    n_cmp++;
    if (ack !== 4'b0100) begin
      n_bad++;
      $display("FAIL drop_ack: got %b expected 0100", ack);
    end
    mem_ack = 0;
  endtask

  task automatic test_fifo_full;
    int acks = 0, extra = 0;
    do_reset();
    req = 4'hF; wr = 4'h0; mem_ack = 1;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (acks == 4 && mem_req) extra++;
      if (ack != 0) begin
        n_cmp++;
        if (ack !== 4'(1 << (acks % 4))) begin
          n_bad++;
          $display("FAIL full_order[%0d]: got %b expected %b", acks, ack, 4'(1 << (acks % 4)));
        end
        acks++;
      end
    end
    n_cmp++;
    if (acks != 4 || extra != 0) begin
      n_bad++;
      $display("FAIL full_block: got %0d grants and %0d extra mem_req cycles, expected 4 and 0", acks, extra);
    end
    mem_rvalid = 1; mem_rdata = 16'h1234;
    #1;
    n_cmp++;
    if ({rvalid, rdata} !== {4'b0001, 16'h1234}) begin
      n_bad++;
      $display("FAIL full_pop: got rvalid=%b rdata=%h expected 0001 1234", rvalid, rdata);
    end
    @(negedge clk);
    mem_rvalid = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    n_cmp++;
    if (!mem_req) begin
      n_bad++;
      $display("FAIL full_slot: got mem_req=%b expected 1 after a slot freed", mem_req);
    end
    @(negedge clk);
    n_cmp++;
    if (ack !== 4'b0001) begin
      n_bad++;
      $display("FAIL full_regrant: got %b expected 0001", ack);
    end
  endtask

  task automatic test_read_order;
    do_reset();
    req = 4'b1000; wr = 0; mem_ack = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack != 0) break;
    end
    n_cmp++;
    if (ack !== 4'b1000) begin
      n_bad++;
      $display("FAIL rd_ack3: got %b expected 1000", ack);
    end
    req = 4'b0010;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack != 0) break;
    end
    n_cmp++;
    if (ack !== 4'b0010) begin
      n_bad++;
      $display("FAIL rd_ack1: got %b expected 0010", ack);
    end
    req = 0;
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 16'hAAAA;
    #1;
    n_cmp++;
    if ({rvalid, rdata} !== {4'b1000, 16'hAAAA}) begin
      n_bad++;
      $display("FAIL rd_ret3: got rvalid=%b rdata=%h expected 1000 aaaa", rvalid, rdata);
    end
    @(negedge clk);
    mem_rdata = 16'h5555;
    #1;
    n_cmp++;
    if ({rvalid, rdata} !== {4'b0010, 16'h5555}) begin
      n_bad++;
      $display("FAIL rd_ret1: got rvalid=%b rdata=%h expected 0010 5555", rvalid, rdata);
    end
    @(negedge clk);
    mem_rvalid = 0;
  endtask

  task automatic test_reset_grant;
    do_reset();
    req = 4'b0010; wr = 0; mem_ack = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack != 0) break;
    end
    req = 4'b0100; wr = 4'b0100; mem_ack = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    n_cmp++;
    if (!mem_req) begin
      n_bad++;
      $display("FAIL rg_grant: got mem_req=%b expected 1", mem_req);
    end
    #2 n_reset = 0;
    #1;
    n_cmp++;
    if ({mem_req, ack} !== 5'b0) begin
      n_bad++;
      $display("FAIL rg_async: got mem_req=%b ack=%b expected 0 0000", mem_req, ack);
    end
    @(negedge clk);
    n_reset = 1; req = 4'hF; wr = 4'hF; mem_ack = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack != 0) break;
    end
    n_cmp++;
    if (ack !== 4'b0001) begin
      n_bad++;
      $display("FAIL rg_first: got %b expected 0001", ack);
    end
    req = 0; mem_ack = 0;
    @(negedge clk);
    @(negedge clk);
    mem_rvalid = 1;
    #1;
    n_cmp++;
    if (rvalid !== 4'b0) begin
      n_bad++;
      $display("FAIL rg_flush: got rvalid=%b expected 0000", rvalid);
    end
    @(negedge clk);
    mem_rvalid = 0;
  endtask

  task automatic test_empty_rvalid;
    do_reset();
    mem_rvalid = 1; mem_rdata = 16'hBEEF;
    #1;
    n_cmp++;
    if (rvalid !== 4'b0) begin
      n_bad++;
      $display("FAIL empty_rvalid: got %b expected 0000", rvalid);
    end
    @(negedge clk);
    mem_rvalid = 0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (dut.err !== 1'b1) begin
        n_bad++;
        $display("FAIL empty_err[%0d]: got %b expected 1", c, dut.err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    logic [3:0] pend = '0, dec_req = '0, dec_wr = '0, exp_rv;
    bit dec_full = 0, dec_valid = 1, acc = 0;
    int q [$];
    int last_g = 3, g_cur = -1, prev_ack = -1, this_ack, dec_excl = -1, w;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      this_ack = -1;
      n_cmp++;
      if (ack !== (acc ? 4'(1 << g_cur) : 4'b0)) begin
        n_bad++;
        $display("FAIL rand_ack cyc %0d: got %b expected %b", cyc, ack, acc ? 4'(1 << g_cur) : 4'b0);
      end
      if (acc) begin
        this_ack = g_cur;
        last_g = g_cur;
        pend[g_cur] = 1'b0;
        g_cur = -1;
      end else if (g_cur < 0 && dec_valid) begin
        w = rr_pick(dec_req, dec_wr, last_g, dec_excl, dec_full);
        if (w >= 0) g_cur = w;
      end
      n_cmp++;
      if (mem_req !== (g_cur >= 0)) begin
        n_bad++;
        $display("FAIL rand_mem_req cyc %0d: got %b expected %b", cyc, mem_req, g_cur >= 0);
      end
      if (g_cur >= 0) begin
        n_cmp++;
        if ({mem_addr, mem_data, mem_wr} !== {addr[g_cur], data[g_cur], wr[g_cur]}) begin
          n_bad++;
          $display("FAIL rand_bus cyc %0d: got %h/%h/%b expected %h/%h/%b (client %0d)", cyc,
                   mem_addr, mem_data, mem_wr, addr[g_cur], data[g_cur], wr[g_cur], g_cur);
        end
      end
      dec_valid = (g_cur < 0) && (this_ack < 0);
      for (int i = 0; i < 4; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          wr[i] = 1'($urandom_range(0, 1));
          addr[i] = 24'($urandom);
          data[i] = 16'($urandom);
        end
      req = pend;
      dec_req = req;
      dec_wr = wr;
      dec_full = q.size() == 4;
      dec_excl = prev_ack;
      mem_ack = 1'($urandom_range(0, 1));
      acc = (g_cur >= 0) && mem_ack;
      mem_rvalid = q.size() > 0 ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      mem_rdata = 16'($urandom);
      exp_rv = (mem_rvalid && q.size() > 0) ? 4'(1 << q[0]) : 4'b0;
      if (mem_rvalid && q.size() > 0) void'(q.pop_front());
      if (acc && !wr[g_cur]) q.push_back(g_cur);
      prev_ack = this_ack;
      #1;
      n_cmp++;
      if (rvalid !== exp_rv) begin
        n_bad++;
        $display("FAIL rand_rvalid cyc %0d: got %b expected %b", cyc, rvalid, exp_rv);
      end
      if (exp_rv != 0) begin
        n_cmp++;
        if (rdata !== mem_rdata) begin
          n_bad++;
          $display("FAIL rand_rdata cyc %0d: got %h expected %h", cyc, rdata, mem_rdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_hold();
    test_drop_req();
    test_fifo_full();
    test_read_order();
    test_reset_grant();
    test_empty_rvalid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arb_rr.md
MEM_ARB_RR -- requirements
Module: mem_arb_rr

Interface
REQ-001 SHALL have parameter N, 4, number of client ports (2..8).
REQ-002 SHALL have parameter AN, 24, address width.
REQ-003 SHALL have parameter DN, 16, data width.
REQ-004 SHALL have parameter FD, 4, read-ID FIFO depth (power of two).
REQ-005 SHALL have port clkSYS  in  1  system clock; one clock, all logic on rising edge.
REQ-006 SHALL have port n_reset  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req  in  N  per-client request; the client holds it high with addr/data/wr stable until ack.
REQ-008 SHALL have port ack  out  N  per-client one-cycle acceptance pulse.
REQ-009 SHALL have port addr  in  N x AN  per-client address.
REQ-010 SHALL have port data  in  N x DN  per-client write data.
REQ-011 SHALL have port wr  in  N  per-client direction: 1 write, 0 read.
REQ-012 SHALL have port rvalid  out  N  per-client read-data strobe.
REQ-013 SHALL have port rdata  out  DN  read data, shared by all clients.
REQ-014 SHALL have port mem_req, mem_wr  out  1 each  memory request, held until mem_ack.
REQ-015 SHALL have port mem_addr, mem_data  out  AN, DN  memory address and data, registered.
REQ-016 SHALL have port mem_ack  in  1  memory accepts the current request in this cycle.
REQ-017 SHALL have port mem_rvalid, mem_rdata  in  1, DN  in-order read return.

Function
REQ-018 SHALL implement FSM Idle -> Grant -> Ack -> Idle.
REQ-019 Idle: if any eligible req, SHALL pick the winner round-robin starting at (last+1) mod N, latch its index g and its addr/data/wr into the mem_* registers, set mem_req=1 and go to Grant.
REQ-020 Eligible SHALL mean req[i]=1, and i != g in the first Idle cycle after Ack; for reads the ID FIFO SHALL also not be full.
REQ-021 Grant: mem_req/mem_addr/mem_data/mem_wr SHALL hold constant; on mem_ack=1 the block SHALL clear mem_req, set last=g and go to Ack; if wr=0, it SHALL push g into the ID FIFO in the same cycle.
REQ-022 Ack: ack[g]=1 for exactly this cycle and all other ack bits 0; next state SHALL be Idle.
REQ-023 Issue rate: at most one request per 3 cycles when mem_ack is returned in the first Grant cycle.
REQ-024 On mem_rvalid=1 the block SHALL pop the FIFO head h, assert rvalid[h]=1 in the same cycle, and drive rdata=mem_rdata combinationally.
REQ-025 Simultaneous push and pop SHALL be legal, including when the FIFO is full, and SHALL leave the count unchanged.
REQ-026 mem_rvalid with an empty FIFO SHALL be ignored (no rvalid bit); a sticky error flag SHALL be set for simulation assertion.
REQ-027 A client dropping req while in Grant SHALL NOT abort the transfer; ack is still issued.
REQ-028 Pointers and last SHALL wrap modulo FD and N respectively; index width SHALL be clog2(N).

Reset
REQ-029 n_reset low SHALL asynchronously force: state=Idle, mem_req=0, mem_wr=0, ack=0, rvalid=0, FIFO empty, error=0, last=N-1 (client 0 wins first); mem_addr/mem_data SHALL be 0.
REQ-030 Reset mid-Grant SHALL drop mem_req immediately with no ack; outstanding read IDs SHALL be discarded.

Structure
REQ-031 The shared display package SHALL hold the FSM state enum and the AN/DN defaults used by the display clients.
REQ-032 The ID FIFO SHALL be one sub-module, id_fifo (width clog2(N), depth FD, push/pop/full/empty/head).

Verification
REQ-033 Reset release with req=4'b0101 and mem_ack always 1: grants SHALL go to 0, then 2, then 0; ack pulses 3 cycles apart.
REQ-034 Client 1 write addr=0x00012C, data=0xF800, mem_ack delayed 5 cycles: mem_* SHALL hold for 5 cycles, then ack[1] SHALL pulse once.
REQ-035 All 4 clients issue reads with FD=4 and mem_rvalid withheld: 4 grants, then no further mem_req for read requests; one mem_rvalid SHALL free a slot.
REQ-036 Reads from clients 3 then 1, with returns 0xAAAA and 0x5555: rvalid[3] SHALL pulse with 0xAAAA, then rvalid[1] with 0x5555.
REQ-037 Assert n_reset low during Grant: mem_req=0 and ack=0 within the same cycle; after release, client 0 SHALL have first priority.
REQ-038 mem_rvalid pulse with the FIFO empty: no rvalid bit set, error flag SHALL be 1.
